// File: rtl/bram_b_reader.sv
// ---------------------------------------------------------------------------
// bram_b_reader: port-B read sequencer streaming BRAM words with backpressure.
// Optional start bounds check: BRAM_READER_BOUNDS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bram_b_reader #(
  parameter int B_WIDTH         = 64,
  parameter int B_ADDRESS_WIDTH = 3,
  parameter int B_DEPTH         = 5,
  parameter int LEN_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [B_ADDRESS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]       start_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       enb,
  output logic                       web,
  output logic [B_ADDRESS_WIDTH-1:0] addrb,
  input  logic [B_WIDTH-1:0]         doutb,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [B_WIDTH-1:0]         m_data,
  output logic                       m_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [B_ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]       issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
  logic                       inflight_q, inflight_d;
  logic                       inflight_last_q, inflight_last_d;
  logic [B_WIDTH-1:0]         fifo_data_q [2];
  logic [B_WIDTH-1:0]         fifo_data_d [2];
  logic [1:0]                 fifo_last_q, fifo_last_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 count_q, count_d;

  logic       pop;
  logic       issue;
  logic       cmd_ok;
  logic       reject;
  logic [2:0] occ;

`ifdef BRAM_READER_BOUNDS_EN
  logic err_q, err_d;
  // Sum widened by one bit so a maximal address plus length cannot alias.
  assign reject = ({1'b0, start_len} + (LEN_WIDTH+1)'(start_addr)) > (LEN_WIDTH+1)'(B_DEPTH);
  assign err    = err_q;
`else
  logic unused_depth;
  assign unused_depth = (B_DEPTH == 0);
  assign reject       = 1'b0;
  assign err          = 1'b0;
`endif

  // Occupancy after this cycle's pop; a new read may only fill a free slot.
  assign pop    = (count_q != 2'd0) & m_ready;
  assign occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == S_READ) && (occ < 3'd2);
  assign cmd_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d         = state_q;
    rd_addr_d       = rd_addr_q;
    issue_cnt_d     = issue_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = issue;
    inflight_last_d = issue && (issue_cnt_q == LEN_WIDTH'(1));
`ifdef BRAM_READER_BOUNDS_EN
    err_d           = 1'b0;
`endif

    if (pop) begin
      beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
      rd_ptr_d   = ~rd_ptr_q;
    end
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = doutb;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd_ok) begin
          if (reject) begin
            state_d = S_DONE;
`ifdef BRAM_READER_BOUNDS_EN
            err_d   = 1'b1;
`endif
          end else if (start_len == '0) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d   = start_addr;
            issue_cnt_d = start_len;
            beat_cnt_d  = start_len;
            state_d     = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + B_ADDRESS_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
          if (issue_cnt_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (beat_cnt_q == LEN_WIDTH'(1))) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rd_addr_q       <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= 2'b00;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
`ifdef BRAM_READER_BOUNDS_EN
      err_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      issue_cnt_q     <= issue_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
`ifdef BRAM_READER_BOUNDS_EN
      err_q           <= err_d;
`endif
    end
  end

  assign busy    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign enb     = issue;
  assign web     = 1'b0;
  assign addrb   = rd_addr_q;
  assign m_valid = (count_q != 2'd0);
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_last  = fifo_last_q[rd_ptr_q] & m_valid;

endmodule

`default_nettype wire

// File: tb/tb_bram_b_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_b_reader: directed and randomized stream checks against a queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bram_b_reader;
  localparam int BW = 64;
  localparam int AW = 3;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] start_len;
  logic          busy, done, err, enb, web;
  logic [AW-1:0] addrb;
  logic [BW-1:0] doutb = '0;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;

  bram_b_reader #(.B_WIDTH(BW), .B_ADDRESS_WIDTH(AW), .B_DEPTH(5), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .start_len(start_len),
    .busy(busy), .done(done), .err(err), .enb(enb), .web(web), .addrb(addrb),
    .doutb(doutb), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // BRAM contents and 1-cycle read latency
  logic [BW-1:0] mem [8];
  initial for (int k = 0; k < 8; k++) mem[k] = 64'h1000 + 64'(k);
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Ready pattern generator: 0 always, 1 random, 2 stalled, 3 pattern 1,0,0
  int rdy_mode = 0;
  int rdy_phase = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      2: m_ready = 1'b0;
      default: m_ready = ((rdy_phase % 3) == 0);
    endcase
    rdy_phase++;
  end

  // Expected reads and stream words per accepted command
  logic [BW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [AW-1:0] exp_addr [$];
  logic zl_flag = 1'b0;
  logic zl_err  = 1'b0;

  function automatic logic is_rej(input int a, input int len);
`ifdef BRAM_READER_BOUNDS_EN
    return (a + len) > 5;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor/scoreboard, sampled on the falling edge
  int   outstanding = 0;
  logic pend_last = 1'b0;
  logic held_v = 1'b0;
  logic [BW-1:0] held_d;
  logic held_l;
  always @(negedge clk) begin
    logic exp_done, pop, l;
    if (rst) begin
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      outstanding = 0; pend_last = 1'b0; held_v = 1'b0;
    end else begin
      exp_done = pend_last | zl_flag;
      if (done || exp_done) check("done", done, exp_done);
      if (err || exp_done) check("err", err, zl_flag & zl_err);
      pop = m_valid & m_ready;
      if (held_v) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held_d);
        check("hold_last", m_last, held_l);
      end
      if (enb) begin
        check("web", web, 0);
        if (exp_addr.size() == 0) check("enb_unexpected", 1, 0);
        else check("addrb", addrb, exp_addr.pop_front());
      end
      if (m_valid && exp_data.size() == 0) check("valid_unexpected", 1, 0);
      pend_last = 1'b0;
      if (pop && exp_data.size() > 0) begin
        check("m_data", m_data, exp_data.pop_front());
        l = exp_last.pop_front();
        check("m_last", m_last, l);
        pend_last = l;
      end
      outstanding = outstanding + int'(enb) - int'(pop);
      if (enb) check("outstanding", outstanding <= 2, 1);
      held_v = m_valid & ~m_ready;
      held_d = m_data;
      held_l = m_last;
    end
  end

  task automatic push_exp(input int a, input int len);
    if (!is_rej(a, len))
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(AW'(a + i));
        exp_data.push_back(mem[AW'(a + i)]);
        exp_last.push_back(i == len - 1);
      end
  endtask

  // Entered and left at posedge+1; returns in cycle 1 of the command
  task automatic send_cmd(input int a, input int len);
    start = 1'b1; start_addr = AW'(a); start_len = LW'(len);
    push_exp(a, len);
    @(posedge clk); #1;
    start = 1'b0;
    zl_flag = (len == 0) || is_rej(a, len);
    zl_err  = is_rej(a, len);
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    logic seen;
    seen = 1'b0; n = -1;
    for (int k = 1; k <= max_cyc && !seen; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; n = k; end
      @(posedge clk); #1;
      zl_flag = 1'b0; zl_err = 1'b0;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  task automatic run_cmd(input int a, input int len);
    int n;
    send_cmd(a, len);
    wait_done(400, n);
    if (len == 0 || is_rej(a, len)) check("done_cycle", 64'(n), 1);
    check("drained", 64'(exp_data.size()), 0);
  endtask

  logic s_enb [8], s_valid [8], s_last [8], s_done [8], s_busy [8];
  logic [BW-1:0] s_data [8];
  logic [AW-1:0] s_addr [8];

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_err", err, 0);       check("rst_enb", enb, 0);
    check("rst_web", web, 0);       check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);   check("rst_addrb", addrb, 0);
    check("rst_data", m_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Directed timing: addr 1, len 3, ready held high
    rdy_mode = 0;
    if (!is_rej(1, 3)) begin
      start = 1'b1; start_addr = 3'd1; start_len = 4'd3;
      push_exp(1, 3);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        s_enb[k] = enb; s_valid[k] = m_valid; s_last[k] = m_last; s_done[k] = done;
        s_busy[k] = busy; s_data[k] = m_data; s_addr[k] = addrb;
        @(posedge clk); #1; start = 1'b0;
      end
      check("t1_enb_c1", s_enb[1], 1);      check("t1_addr_c1", s_addr[1], 1);
      check("t1_busy_c1", s_busy[1], 1);    check("t1_valid_c2", s_valid[2], 0);
      check("t1_valid_c3", s_valid[3], 1);  check("t1_data_c3", s_data[3], 64'h1001);
      check("t1_data_c4", s_data[4], 64'h1002); check("t1_last_c4", s_last[4], 0);
      check("t1_data_c5", s_data[5], 64'h1003); check("t1_last_c5", s_last[5], 1);
      check("t1_done_c5", s_done[5], 0);    check("t1_done_c6", s_done[6], 1);
      check("t1_busy_c6", s_busy[6], 0);    check("t1_valid_c6", s_valid[6], 0);
    end

    // Throttled delivery
    rdy_mode = 3;
    run_cmd(1, 3);
    run_cmd(0, 5);

    // Zero length
    rdy_mode = 0;
    run_cmd(5, 0);

    // Start while busy is ignored
    begin
      int n;
      rdy_mode = 2;
      send_cmd(2, 3);
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b1; start_addr = 3'd6; start_len = 4'd2;
      @(posedge clk); #1; start = 1'b0;
      rdy_mode = 1;
      wait_done(400, n);
      check("busy_ign_drained", 64'(exp_data.size()), 0);
    end

    // Address wrap / bounds rejection
    rdy_mode = 0;
    run_cmd(7, 2);
    run_cmd(4, 2);
    run_cmd(0, 5);

    // Reset with two words buffered
    rdy_mode = 2;
    send_cmd(0, 4);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_rst_valid", m_valid, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; zl_flag = 1'b0;
    @(negedge clk);
    check("post_rst_valid", m_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    @(negedge clk);
    check("post_rst_valid2", m_valid, 0);
    check("post_rst_done2", done, 0);
    @(posedge clk); #1;
    rdy_mode = 1;
    run_cmd(1, 4);

    // Randomized commands
    for (int r = 0; r < 40; r++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
